// File: rtl/face_collector_if.sv
// Result stream carrying collected face records from face_collector to its consumer.
interface face_collector_if;
  // A record transfers on a rising clock edge where out_valid and out_ready are both high.
  // out_valid never depends on out_ready. While out_valid=1 and out_ready=0 the producer
  // holds out_x/out_y/out_pyramid stable. out_last qualifies the final record of a frame.
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [3:0]  out_pyramid;
  logic        out_last;

  modport master (
    output out_valid,
    output out_x,
    output out_y,
    output out_pyramid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_x,
    input  out_y,
    input  out_pyramid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/face_collector.sv
// Collects classifier face hits into a FWFT FIFO with duplicate suppression and per-frame
// statistics; a frame FSM waits out pipeline latency, drains, tags the last record, pulses done.
module face_collector #(
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic [1:0][31:0]  top_left,
  input  logic [3:0]        pyramid_number,
  input  logic              top_left_ready,
  face_collector_if.master  out_if,
  output logic [15:0]       face_count,
  output logic [15:0]       drop_count,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int REC_W = 68;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_SETTLE  = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [15:0]      face_q, face_d;
  logic [15:0]      drop_q, drop_d;
  logic [REC_W-1:0] filt_q, filt_d;
  logic             filt_valid_q, filt_valid_d;

  logic [REC_W-1:0] mem [DEPTH];

  logic [REC_W-1:0] det_rec;
  logic [REC_W-1:0] head_rec;
  logic [PW-1:0]    occupancy;
  logic             empty;
  logic             full;
  logic             pop;
  logic             capture_en;
  logic             is_dup;
  logic             candidate;
  logic             push;
  logic             drop;

  assign det_rec   = {top_left[0], top_left[1], pyramid_number};
  assign head_rec  = mem[rd_ptr_q[AW-1:0]];
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = !empty && out_if.out_ready;

  // The filter needs its own valid bit so a cleared register never matches a real (0,0,L0) hit.
  assign capture_en = (state_q == S_COLLECT) || (state_q == S_SETTLE);
  assign is_dup     = filt_valid_q && (filt_q == det_rec);
  assign candidate  = capture_en && top_left_ready && !is_dup;
  assign push       = candidate && (!full || pop);
  assign drop       = candidate && full && !pop;

  // Frame state machine.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      settle_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (frame_end) begin
          state_d  = S_SETTLE;
          settle_d = 8'(SETTLE_CYCLES);
        end
      end
      S_SETTLE: begin
        // Hits are still taken in the cycle where the counter reads 1.
        settle_d = settle_q - 8'd1;
        if (settle_q <= 8'd1) begin
          state_d  = S_FLUSH;
          settle_d = 8'd0;
        end
      end
      S_FLUSH: begin
        if (empty) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        settle_d = 8'd0;
      end
    endcase
  end

  // FIFO pointers, statistics and duplicate filter.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    face_d       = face_q;
    drop_d       = drop_q;
    filt_d       = filt_q;
    filt_valid_d = filt_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (state_q == S_IDLE) begin
      face_d       = 16'd0;
      drop_d       = 16'd0;
      filt_valid_d = 1'b0;
    end else begin
      if (push) begin
        filt_d       = det_rec;
        filt_valid_d = 1'b1;
        if (face_q != 16'hFFFF) face_d = face_q + 16'd1;
      end
      if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      face_q       <= 16'd0;
      drop_q       <= 16'd0;
      filt_q       <= '0;
      filt_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      face_q       <= face_d;
      drop_q       <= drop_d;
      filt_q       <= filt_d;
      filt_valid_q <= filt_valid_d;
    end
  end

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= det_rec;
  end

  assign out_if.out_valid   = !empty;
  assign out_if.out_x       = empty ? 32'd0 : head_rec[67:36];
  assign out_if.out_y       = empty ? 32'd0 : head_rec[35:4];
  assign out_if.out_pyramid = empty ? 4'd0  : head_rec[3:0];
  assign out_if.out_last    = (state_q == S_FLUSH) && (occupancy == PW'(1));

  assign face_count  = face_q;
  assign drop_count  = drop_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && empty));
  a_hold_payload: assert property (@(posedge clock) disable iff (!reset_n)
    (out_if.out_valid && !out_if.out_ready) |=>
      $stable({out_if.out_x, out_if.out_y, out_if.out_pyramid}));

endmodule
